pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 32, meaning width of the stage payload (pipeline data/control bundle).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each saturating performance counter.
REQ-003 SHALL have parameter CLEAR_ON_FLUSH, default 1, meaning payload registers are zeroed when a flush takes effect (0 = payload is held, valid is cleared).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush, input, 1, which kills all held entries (branch mispredict or trap).
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_payload (input, PAYLOAD_W), the upstream handshake.
REQ-008 SHALL have port in_invalid, input, 1, the illegal-instruction flag travelling with in_payload.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_payload (output, PAYLOAD_W) and out_invalid (output, 1), the downstream handshake.
REQ-010 SHALL have ports stall_cnt (output, CNT_W) and flush_cnt (output, CNT_W), the performance counters.

Function
REQ-011 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-012 SHALL hold two entries: main (drives out_*) and skid; the state is EMPTY (0 entries), ONE (main valid) or FULL (main and skid valid).
REQ-013 SHALL drive in_ready = (state != FULL) from a register, never combinationally from out_ready.
REQ-014 SHALL have 1-cycle latency: a word accepted in EMPTY appears on out_* the next cycle.
REQ-015 SHALL make the following transitions: EMPTY + accept -> ONE; ONE + accept + no drain -> FULL (word goes to skid); ONE + accept + drain -> ONE (main takes the new word); ONE + drain only -> EMPTY.
REQ-016 SHALL make the following transitions: FULL + drain -> ONE with skid moved to main; no accept is possible in FULL.
REQ-017 SHALL keep out_payload and out_invalid stable while out_valid && !out_ready.
REQ-018 SHALL preserve order: no entry overtakes another and none is dropped or duplicated.
REQ-019 SHALL, when flush is high at a clock edge, go to EMPTY, assert in_ready and discard any simultaneous input transfer; flush overrides every other event.
REQ-020 SHALL treat a downstream transfer in the flush cycle as completed (the downstream stage sees it), and SHALL apply CLEAR_ON_FLUSH to the main and skid payloads.
REQ-021 SHALL increment stall_cnt on each cycle with out_valid && !out_ready, saturating at all-ones.
REQ-022 SHALL increment flush_cnt on each cycle with flush high while state != EMPTY, saturating at all-ones.
REQ-023 SHALL carry in_invalid unchanged alongside its payload; it SHALL NOT affect the handshake.

Reset
REQ-024 SHALL, on assertion of reset (low), immediately set state EMPTY, out_valid 0, out_payload 0, out_invalid 0, skid contents 0, stall_cnt 0 and flush_cnt 0.
REQ-025 SHALL drive in_ready 0 while reset is asserted and 1 from the first clock edge after deassertion.
REQ-026 SHALL, on reset asserted mid-transfer, lose all entries with no partial output.

Structure
REQ-027 SHALL take the state enum (EMPTY/ONE/FULL) and default parameter constants from the shared core package pipe_pkg.
REQ-028 SHALL implement the saturating counter as one sub-module, sat_counter, instantiated twice.
REQ-029 SHALL be instantiable as IF/ID, ID/EX, EX/MEM and MEM/WB by setting PAYLOAD_W to the packed width of each stage bundle.

Verification
REQ-030 SHALL cover: after reset, push 0xA5A5A5A5 with out_ready=1 -> out_valid next cycle with out_payload 0xA5A5A5A5, in_ready stays 1.
REQ-031 SHALL cover: out_ready=0, push 0x11 then 0x22 -> FULL, in_ready=0, stall_cnt counts up; then out_ready=1 -> 0x11 then 0x22 on consecutive cycles.
REQ-032 SHALL cover: FULL with flush=1 and in_valid=1 (0x33) -> next cycle out_valid=0, in_ready=1, 0x33 never emitted, flush_cnt=1, payload 0 when CLEAR_ON_FLUSH=1.
REQ-033 SHALL cover: in_valid=1 and out_ready=1 for 100 cycles with incrementing data -> 100 outputs in order, no bubbles, stall_cnt=0.
REQ-034 SHALL cover: CNT_W=4 with out_ready=0 held 20 cycles -> stall_cnt saturates at 15 and stays there.
REQ-035 SHALL cover: reset asserted low mid-cycle in FULL -> out_valid=0 and counters 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-core definitions: stage occupancy states and default
// parameter values used by every pipeline register stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int PAYLOAD_W_DEF      = 32;
  localparam int CNT_W_DEF          = 16;
  localparam int CLEAR_ON_FLUSH_DEF = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// pipeline stage performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register (main + skid) with a registered in_ready,
// flush support and saturating stall/flush performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W      = PAYLOAD_W_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int CLEAR_ON_FLUSH = CLEAR_ON_FLUSH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_invalid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_invalid,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [1:0]           state_dbg
);

  // Handshake: a word moves upstream->stage when in_valid && in_ready and
  // stage->downstream when out_valid && out_ready; neither valid may wait on
  // the matching ready, and in_ready depends only on registered state.

  localparam int ENTRY_W = PAYLOAD_W + 1;

  stage_state_e       state_q, state_d;
  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic [ENTRY_W-1:0] in_entry;
  logic               in_ready_q;
  logic               accept;
  logic               drain;
  logic               stall_inc;
  logic               flush_inc;

  // The illegal-instruction flag rides as the top bit of each entry.
  assign in_entry    = {in_invalid, in_payload};
  assign accept      = in_valid && in_ready_q;
  assign drain       = out_valid && out_ready;

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_payload = main_q[PAYLOAD_W-1:0];
  assign out_invalid = main_q[ENTRY_W-1];
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so draining is the only possible event.
          if (drain) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign stall_inc = out_valid && !out_ready;
  assign flush_inc = flush && (state_q != ST_EMPTY);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a default-width instance and a CNT_W=4 instance
// share stimulus and are both checked every cycle against a queue model.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int PW     = 32;
  localparam int CW     = 16;
  localparam int CW_SAT = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [PW-1:0]     in_payload;
  logic              in_invalid;
  logic              out_ready;

  logic              in_ready;
  logic              out_valid;
  logic [PW-1:0]     out_payload;
  logic              out_invalid;
  logic [CW-1:0]     stall_cnt;
  logic [CW-1:0]     flush_cnt;
  logic [1:0]        state_dbg;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [PW-1:0]     s_out_payload;
  logic              s_out_invalid;
  logic [CW_SAT-1:0] s_stall_cnt;
  logic [CW_SAT-1:0] s_flush_cnt;
  logic [1:0]        s_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  bit check_en = 0;

  typedef logic [PW:0] entry_t;
  entry_t      exp_q[$];
  entry_t      m_head;
  bit          m_in_ready = 0;
  bit          m_cleared  = 1;
  bit          m_acc;
  bit          m_drn;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  pipe_stage_skid #(
    .PAYLOAD_W      (PW),
    .CNT_W          (CW),
    .CLEAR_ON_FLUSH (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_invalid  (in_invalid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_invalid (out_invalid),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .state_dbg   (state_dbg)
  );

  pipe_stage_skid #(
    .PAYLOAD_W      (PW),
    .CNT_W          (CW_SAT),
    .CLEAR_ON_FLUSH (1)
  ) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (s_in_ready),
    .in_payload  (in_payload),
    .in_invalid  (in_invalid),
    .out_valid   (s_out_valid),
    .out_ready   (out_ready),
    .out_payload (s_out_payload),
    .out_invalid (s_out_invalid),
    .stall_cnt   (s_stall_cnt),
    .flush_cnt   (s_flush_cnt),
    .state_dbg   (s_state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  // Driver
  task automatic drive(input logic v, input logic [PW-1:0] d, input logic inv);
    in_valid   = v;
    in_payload = d;
    in_invalid = inv;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int unsigned v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (64'(v) > max_v) ? max_v : 64'(v);
  endfunction

  // Behavioural model: the stage is a FIFO of at most two words.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_in_ready = 0;
      m_cleared  = 1;
      m_stall    = 0;
      m_flush    = 0;
    end else begin
      m_acc = in_valid && m_in_ready;
      m_drn = (exp_q.size() > 0) && out_ready;
      if (exp_q.size() > 0 && !out_ready) m_stall++;
      if (flush && exp_q.size() > 0) m_flush++;
      if (flush) begin
        exp_q.delete();
        m_cleared = 1;
      end else begin
        if (m_drn) void'(exp_q.pop_front());
        if (m_acc) begin
          exp_q.push_back({in_invalid, in_payload});
          m_cleared = 0;
        end
      end
      m_in_ready = (exp_q.size() < 2);
    end
  end

  // Scoreboard compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("out_valid", out_valid, exp_q.size() > 0);
      check("in_ready", in_ready, m_in_ready);
      check("state_dbg", state_dbg, exp_q.size());
      check("stall_cnt", stall_cnt, sat(m_stall, CW));
      check("flush_cnt", flush_cnt, sat(m_flush, CW));
      check("sat_out_valid", s_out_valid, exp_q.size() > 0);
      check("sat_in_ready", s_in_ready, m_in_ready);
      check("sat_state_dbg", s_state_dbg, exp_q.size());
      check("sat_stall_cnt", s_stall_cnt, sat(m_stall, CW_SAT));
      check("sat_flush_cnt", s_flush_cnt, sat(m_flush, CW_SAT));
      if (exp_q.size() > 0) begin
        m_head = exp_q[0];
        check("out_payload", out_payload, m_head[PW-1:0]);
        check("out_invalid", out_invalid, m_head[PW]);
        check("sat_out_payload", s_out_payload, m_head[PW-1:0]);
      end else if (m_cleared) begin
        check("cleared_payload", out_payload, 0);
        check("cleared_invalid", out_invalid, 0);
      end
    end
  end

  // Directed stimulus
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0);
    #1 reset = 1'b0;
    #1 check_en = 1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_payload", out_payload, 0);
    check("rst_stall", stall_cnt, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    // Single word, 1-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'hA5A5_A5A5, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    check("a_valid", out_valid, 1);
    check("a_payload", out_payload, 32'hA5A5_A5A5);
    check("a_in_ready", in_ready, 1);
    @(negedge clk);
    check("a_drained", out_valid, 0);

    // Fill to FULL under backpressure, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h22, 1'b0);
    @(negedge clk);
    check("b_in_ready_full", in_ready, 0);
    check("b_stall1", stall_cnt, 1);
    drive(1'b1, 32'hDEAD, 1'b0);
    repeat (3) @(negedge clk);
    check("b_stall4", stall_cnt, 4);
    check("b_head", out_payload, 32'h11);
    check("b_head_inv", out_invalid, 1);
    drive(1'b0, '0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("b_second", out_payload, 32'h22);
    check("b_second_inv", out_invalid, 0);
    @(negedge clk);
    check("b_empty", out_valid, 0);
    check("b_stall_hold", stall_cnt, 4);

    // Flush in FULL with a simultaneous push
    out_ready = 1'b0;
    drive(1'b1, 32'h44, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h55, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 32'h33, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("c_valid", out_valid, 0);
    check("c_in_ready", in_ready, 1);
    check("c_flush_cnt", flush_cnt, 1);
    check("c_payload", out_payload, 0);
    check("c_stall", stall_cnt, 6);
    @(negedge clk);
    check("c_no_33", out_valid, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("c_flush_empty", flush_cnt, 1);
    out_ready = 1'b1;
    drive(1'b1, 32'h66, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("c_flush_drain", flush_cnt, 2);
    check("c_flush_drain_valid", out_valid, 0);

    // Back-to-back streaming, no bubbles
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 1'(i));
      @(negedge clk);
      check("d_valid", out_valid, 1);
      check("d_payload", out_payload, 32'h1000 + 32'(i));
      if (out_valid && out_payload == 32'h1000 + 32'(i)) n_out++;
    end
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("d_count", n_out, 100);
    check("d_stall", stall_cnt, 0);

    // Counter saturation on the CNT_W=4 instance
    out_ready = 1'b0;
    drive(1'b1, 32'h77, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    repeat (20) @(negedge clk);
    check("e_sat15", s_stall_cnt, 15);
    check("e_wide20", stall_cnt, 20);
    repeat (5) @(negedge clk);
    check("e_sat_hold", s_stall_cnt, 15);

    // Asynchronous reset in FULL
    drive(1'b1, 32'h88, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    check("f_full", in_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("f_async_valid", out_valid, 0);
    check("f_async_in_ready", in_ready, 0);
    check("f_async_stall", stall_cnt, 0);
    check("f_async_flush", flush_cnt, 0);
    check("f_async_sat_stall", s_stall_cnt, 0);
    check("f_async_payload", out_payload, 0);
    check("f_async_state", state_dbg, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("f_in_ready", in_ready, 1);
    check("f_no_partial", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 32'h99, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    check("f_alive_payload", out_payload, 32'h99);
    check("f_alive_inv", out_invalid, 1);
    @(negedge clk);
    check_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
